// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch unit feeding a FIFO toward decode.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   imem_req/imem_addr                   fetch request and word-aligned address (valid while imem_req=1)
//   imem_gnt/imem_rvalid/imem_rdata      memory grant, read-data valid, instruction word
//   redirect_valid/redirect_pc           branch/jump redirect; flushes the queue
//   if_valid/if_ready                    queue-head handshake toward decode
//   if_instruction/if_pc                 head instruction and its address (last popped value when empty)
//   fetch_starve_cnt                     only with FETCH_PERF_CNT_EN: cycles decode was ready but starved
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_starve_cnt
`endif
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DISCARD} state_t;
  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc, w_pc_nxt, r_req_pc, r_last_pc, r_last_ins;
  logic [31:0]   r_q_pc  [QUEUE_DEPTH];
  logic [31:0]   r_q_ins [QUEUE_DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          w_grant, w_push, w_pop;
  assign w_grant        = r_state == REQ && imem_gnt;
  // a redirect voids both the push of a coinciding response and any pop
  assign w_push         = r_state == RESP && imem_rvalid && !redirect_valid;
  assign w_pop          = if_valid && if_ready && !redirect_valid;
  assign w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);
  assign imem_req       = r_state == REQ;
  assign imem_addr      = r_pc;
  assign if_valid       = r_count != '0;
  assign if_instruction = if_valid ? r_q_ins[r_head] : r_last_ins;
  assign if_pc          = if_valid ? r_q_pc[r_head] : r_last_pc;
  assign w_pc_nxt       = redirect_valid ? {redirect_pc[31:2], 2'b00} : w_grant ? r_pc + 32'd4 : r_pc;
  // DISCARD absorbs the response of a request that was granted before a redirect;
  // once that response is seen (even alongside another redirect) nothing is outstanding.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = (!redirect_valid && r_count < DEPTH) ? REQ : IDLE;
      REQ:     w_state_nxt = redirect_valid ? (imem_gnt ? DISCARD : IDLE) : (imem_gnt ? RESP : REQ);
      RESP:    w_state_nxt = redirect_valid ? (imem_rvalid ? IDLE : DISCARD) :
                             !imem_rvalid ? RESP : (w_count_nxt < DEPTH) ? REQ : IDLE;
      DISCARD: w_state_nxt = imem_rvalid ? IDLE : DISCARD;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_last_pc  <= '0;
      r_last_ins <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_grant) r_req_pc <= r_pc;
      if (w_pop) begin
        r_last_pc  <= r_q_pc[r_head];
        r_last_ins <= r_q_ins[r_head];
      end
      r_head  <= redirect_valid ? '0 : r_head + AW'(w_pop);
      r_tail  <= redirect_valid ? '0 : r_tail + AW'(w_push);
      r_count <= redirect_valid ? '0 : w_count_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]  <= r_req_pc;
      r_q_ins[r_tail] <= imem_rdata;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_starve_cnt;
  assign fetch_starve_cnt = r_starve_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_starve_cnt <= '0;
    else if (if_ready && !if_valid && r_starve_cnt != '1) r_starve_cnt <= r_starve_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table, corner sequences and random traffic against a program-order model.
module tb_instruction_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, if_valid, if_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instruction, if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_starve_cnt;
`endif
  always #5 clk = ~clk;
  instruction_fetch #(.RESET_PC(RPC), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instruction(if_instruction), .if_pc(if_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_starve_cnt(fetch_starve_cnt)
`endif
  );
  int          n_checks = 0, n_fail = 0;
  logic [31:0] exp_fetch, exp_pop, paddr;
  bit          pending, prev_redir;
  int          wait_c, lat_max, n_gnt, n_pop, req_seen;
  typedef struct {
    logic gnt, rv; logic [31:0] rdata; logic redir; logic [31:0] rpc; logic rdy;
    logic e_req; logic [31:0] e_addr; logic e_val; logic [31:0] e_pc, e_ins;
  } vec_t;
  vec_t tv[21];
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction
  function automatic vec_t v(input logic gnt, rv, input logic [31:0] ra, input logic redir,
                             input logic [31:0] rpc, input logic rdy, er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep);
    vec_t r;
    r.gnt = gnt; r.rv = rv; r.rdata = rv ? mem_data(ra) : 32'h0; r.redir = redir; r.rpc = rpc;
    r.rdy = rdy; r.e_req = er; r.e_addr = ea; r.e_val = ev; r.e_pc = ep;
    r.e_ins = (ep == 32'h0) ? 32'h0 : mem_data(ep);
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; if_ready = 0;
    @(posedge clk); #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_ins", if_instruction, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_starve", fetch_starve_cnt, 0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_fetch = RPC; exp_pop = RPC; pending = 0; prev_redir = 0; n_gnt = 0; n_pop = 0;
  endtask
  // One cycle of traffic: memory responder plus program-order checks on fetch and pop streams.
  task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = rpc & ~32'h3;
    if (prev_redir) chk("flush_valid", if_valid, 0);
    if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
    imem_gnt = gnt; if_ready = rdy; redirect_valid = redir; redirect_pc = rpc; imem_rvalid = 0;
    if (pending) begin
      wait_c--;
      if (wait_c == 0) begin
        imem_rvalid = 1; imem_rdata = mem_data(paddr); pending = 0;
      end
    end
    if (if_valid && rdy && !redir) begin
      chk("pop_pc", if_pc, exp_pop);
      chk("pop_ins", if_instruction, mem_data(exp_pop));
      exp_pop += 4; n_pop++;
    end
    if (imem_req && gnt) begin
      n_gnt++; pending = 1; paddr = imem_addr; wait_c = int'($urandom_range(lat_max, 1));
      if (!redir) exp_fetch += 4;
    end
    if (redir) begin
      exp_fetch = tgt; exp_pop = tgt;
    end
    prev_redir = redir;
    @(posedge clk); #1;
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    //          gnt rv ra          rd rpc           rdy req addr          val pc
    tv[0]  = v(1, 0, 0,          0, 0,          1,  0, 0,           0, 0);
    tv[1]  = v(1, 0, 0,          0, 0,          1,  1, 32'h100,     0, 0);
    tv[2]  = v(1, 1, 32'h100,    0, 0,          1,  0, 0,           0, 0);
    tv[3]  = v(1, 0, 0,          0, 0,          1,  1, 32'h104,     1, 32'h100);
    tv[4]  = v(1, 1, 32'h104,    0, 0,          1,  0, 0,           0, 32'h100);
    tv[5]  = v(1, 0, 0,          0, 0,          1,  1, 32'h108,     1, 32'h104);
    tv[6]  = v(1, 1, 32'h108,    0, 0,          1,  0, 0,           0, 32'h104);
    tv[7]  = v(1, 0, 0,          0, 0,          0,  1, 32'h10C,     1, 32'h108);
    tv[8]  = v(1, 0, 0,          1, 32'h203,    1,  0, 0,           1, 32'h108);
    tv[9]  = v(1, 1, 32'h10C,    0, 0,          1,  0, 0,           0, 32'h104);
    tv[10] = v(1, 0, 0,          0, 0,          1,  0, 0,           0, 32'h104);
    tv[11] = v(1, 0, 0,          0, 0,          1,  1, 32'h200,     0, 32'h104);
    tv[12] = v(1, 1, 32'h200,    0, 0,          1,  0, 0,           0, 32'h104);
    tv[13] = v(0, 0, 0,          0, 0,          0,  1, 32'h204,     1, 32'h200);
    tv[14] = v(1, 0, 0,          1, 32'h300,    1,  1, 32'h204,     1, 32'h200);
    tv[15] = v(1, 1, 32'h204,    0, 0,          1,  0, 0,           0, 32'h104);
    tv[16] = v(1, 0, 0,          0, 0,          1,  0, 0,           0, 32'h104);
    tv[17] = v(1, 0, 0,          0, 0,          1,  1, 32'h300,     0, 32'h104);
    tv[18] = v(1, 1, 32'h300,    0, 0,          1,  0, 0,           0, 32'h104);
    tv[19] = v(0, 0, 0,          0, 0,          1,  1, 32'h304,     1, 32'h300);
    tv[20] = v(0, 0, 0,          0, 0,          1,  1, 32'h304,     0, 32'h300);
    lat_max = 1;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("tv%0d_req", i), imem_req, tv[i].e_req);
      if (tv[i].e_req) chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].e_addr);
      chk($sformatf("tv%0d_valid", i), if_valid, tv[i].e_val);
      chk($sformatf("tv%0d_pc", i), if_pc, tv[i].e_pc);
      chk($sformatf("tv%0d_ins", i), if_instruction, tv[i].e_ins);
      imem_gnt = tv[i].gnt; imem_rvalid = tv[i].rv; imem_rdata = tv[i].rdata;
      redirect_valid = tv[i].redir; redirect_pc = tv[i].rpc; if_ready = tv[i].rdy;
      @(posedge clk); #1;
    end
    do_reset();
    req_seen = 0;
    for (int i = 0; i < 24; i++) begin
      if (i >= 16 && imem_req) req_seen++;
      step(1, 0, 0, 0);
    end
    chk("full_grants", n_gnt, 4);
    chk("full_req_low", req_seen, 0);
    chk("full_valid", if_valid, 1);
    n_pop = 0;
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
    chk("drain_progress", n_pop >= 12, 1);
    lat_max = 3; n_pop = 0;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, $urandom_range(24, 0) == 0, $urandom);
    chk("rand_progress", n_pop > 200, 1);
    for (int i = 0; i < 20 && !pending; i++) step(1, 1, 0, 0);
    chk("mid_pending", pending, 1);
    do_reset();
    imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0; if_ready = 1;
    @(posedge clk); #1;
    imem_rvalid = 0;
    chk("late_rv_drop", if_valid, 0);
    lat_max = 1; n_pop = 0;
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
    chk("post_rst_progress", n_pop >= 3, 1);
`ifdef FETCH_PERF_CNT_EN
    do_reset();
    if_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("starve_cnt", fetch_starve_cnt, 10);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4: instruction queue entries; power of two, at least 2.
REQ-003 SHALL use a single clock and an asynchronous active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  word-aligned fetch address; valid while imem_req=1.
REQ-008 imem_gnt  in  1  memory accepts the request this cycle.
REQ-009 imem_rvalid  in  1  read data valid; at most one per granted request, at least 1 cycle after grant.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 redirect_valid  in  1  branch/jump redirect from execute.
REQ-012 redirect_pc  in  32  redirect target.
REQ-013 if_valid  out  1  queue head valid toward decode.
REQ-014 if_ready  in  1  decode accepts the head this cycle.
REQ-015 if_instruction  out  32  head instruction, instruction_type from common package.
REQ-016 if_pc  out  32  address of the head instruction.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, RESP and DISCARD, with at most one outstanding memory request.
REQ-018 IDLE->REQ SHALL occur when queue count < QUEUE_DEPTH and redirect_valid=0; imem_req=1 only in REQ; imem_addr=pc.
REQ-019 REQ with imem_gnt=1 SHALL latch req_pc=pc, set pc<=pc+4 (mod 2^32), and go to RESP; without a grant the FSM stays in REQ with imem_req and imem_addr held.
REQ-020 RESP with imem_rvalid=1 SHALL push {req_pc, imem_rdata} into the queue and go to REQ if space remains after that cycle's push/pop, else IDLE.
REQ-021 Latency SHALL be: rvalid at cycle t gives if_valid=1 at t+1 when the queue was empty (no bypass).
REQ-022 A queue entry SHALL pop when if_valid=1 and if_ready=1; a simultaneous push and pop leaves the count unchanged.
REQ-023 Queue overflow SHALL be impossible by construction (REQ-018); if_valid=0 when empty; if_instruction and if_pc SHALL hold the last popped value when empty.
REQ-024 redirect_valid=1 SHALL flush the queue in the same edge; if_valid=0 next cycle; any pop in that cycle is void.
REQ-025 On redirect, pc SHALL load {redirect_pc[31:2],2'b00}.
REQ-026 On redirect, the next state SHALL be DISCARD if the current state is RESP without rvalid, or REQ with imem_gnt=1; otherwise IDLE.
REQ-027 If redirect_valid and imem_rvalid coincide in RESP, the data SHALL be dropped and the next state SHALL be IDLE.
REQ-028 DISCARD SHALL drop the next imem_rvalid without pushing and then go to IDLE; a redirect in DISCARD updates pc and remains in DISCARD.
REQ-029 imem_req SHALL deassert in the cycle after a redirect unless the FSM re-enters REQ; a redirect has priority over all other events.

Reset
REQ-030 Reset SHALL set pc=RESET_PC, state=IDLE, queue empty, imem_req=0, if_valid=0, if_instruction=0, if_pc=0.
REQ-031 imem_req SHALL assert in the 2nd rising edge's cycle after reset_n deasserts (IDLE->REQ).
REQ-032 Reset asserted mid-transaction SHALL abandon the outstanding request; a late rvalid after reset, while IDLE, SHALL be ignored.

Configuration
REQ-033 Macro FETCH_PERF_CNT_EN defined: output fetch_starve_cnt (32, out) SHALL count cycles with if_ready=1 and if_valid=0, reset to 0, and saturate at 32'hFFFF_FFFF.
REQ-034 FETCH_PERF_CNT_EN undefined: no port and no counter logic.

Verification
REQ-035 Reset with RESET_PC=0x100, gnt=1 always, rvalid 1 cycle after gnt, if_ready=1 -> if_pc sequence 0x100,0x104,0x108 with matching rdata.
REQ-036 if_ready=0 and QUEUE_DEPTH=4 -> exactly 4 entries queued, imem_req stays 0 afterward, and no entry is lost when if_ready rises.
REQ-037 Redirect to 0x203 while in RESP -> the following rvalid is dropped, the next imem_addr=0x200, and if_valid=0 the cycle after the redirect.
REQ-038 Redirect in the same cycle as imem_gnt -> DISCARD, one rvalid dropped, then fetch resumes at the target.
REQ-039 Queue full with if_ready=1 during a push -> count stays at 4 and order is preserved.
REQ-040 With FETCH_PERF_CNT_EN defined, if_ready=1 for 10 cycles with an empty queue -> fetch_starve_cnt=10.
